// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute unit: ALU control codes,
// decode-stage ALUOp codes and the control FSM state type.
package alu_pkg;

  // 4-bit ALU control codes; the original 4-bit encoding extended with
  // XOR, SLTU, the three shifts and MUL.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  // ALUOp as produced by the main decoder.
  localparam logic [1:0] OP_LOAD_STORE = 2'b00;
  localparam logic [1:0] OP_BRANCH     = 2'b01;
  localparam logic [1:0] OP_RTYPE      = 2'b10;
  localparam logic [1:0] OP_ITYPE      = 2'b11;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_DONE     = 2'b10
  } state_t;

  // True when a decoded control code selects the iterative multiplier.
  function automatic logic is_mul(input logic [3:0] ctl);
    return (ctl == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU-control decode: {ALUOp, funct7, funct3} -> 4-bit code.
// Kept free of state so a single-cycle core can reuse it unchanged.
module alu_ctl_decode
  import alu_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic [1:0] i_alu_op,
  input  logic [6:0] i_funct7,
  input  logic [2:0] i_funct3,
  output logic [3:0] o_alu_ctl
);

  logic [3:0] w_rtype_key;
  logic       w_is_mul_enc;

  assign w_rtype_key  = {i_funct7[5], i_funct3};
  assign w_is_mul_enc = (i_funct7 == 7'b0000001) && (i_funct3 == 3'b000);

  // Decode table; anything not listed falls back to AND.
  always_comb begin
    o_alu_ctl = ALU_AND;
    case (i_alu_op)
      OP_LOAD_STORE: o_alu_ctl = ALU_ADD;
      OP_BRANCH:     o_alu_ctl = ALU_SUB;
      OP_RTYPE: begin
        if (w_is_mul_enc) begin
          // Without a multiplier the MUL encoding degrades to ADD.
          if (MUL_EN != 0) begin
            o_alu_ctl = ALU_MUL;
          end else begin
            o_alu_ctl = ALU_ADD;
          end
        end else begin
          case (w_rtype_key)
            4'b0000: o_alu_ctl = ALU_ADD;
            4'b1000: o_alu_ctl = ALU_SUB;
            4'b0111: o_alu_ctl = ALU_AND;
            4'b0110: o_alu_ctl = ALU_OR;
            4'b0100: o_alu_ctl = ALU_XOR;
            4'b0010: o_alu_ctl = ALU_SLT;
            4'b0011: o_alu_ctl = ALU_SLTU;
            4'b0001: o_alu_ctl = ALU_SLL;
            4'b0101: o_alu_ctl = ALU_SRL;
            4'b1101: o_alu_ctl = ALU_SRA;
            default: o_alu_ctl = ALU_AND;
          endcase
        end
      end
      OP_ITYPE: begin
        case (i_funct3)
          3'b000:  o_alu_ctl = ALU_ADD;
          3'b111:  o_alu_ctl = ALU_AND;
          3'b110:  o_alu_ctl = ALU_OR;
          3'b100:  o_alu_ctl = ALU_XOR;
          3'b010:  o_alu_ctl = ALU_SLT;
          3'b011:  o_alu_ctl = ALU_SLTU;
          3'b001:  o_alu_ctl = ALU_SLL;
          3'b101:  o_alu_ctl = i_funct7[5] ? ALU_SRA : ALU_SRL;
          default: o_alu_ctl = ALU_AND;
        endcase
      end
      default: o_alu_ctl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute unit between decode and writeback: decodes the ALU control,
// computes single-cycle results in one pass and runs MUL as a shift-add
// loop of XLEN iterations. Results are held until the consumer accepts.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctl
);

  localparam int              SHW      = $clog2(XLEN);
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic [3:0]      r_ctl;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;

  logic [3:0]      w_ctl;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_acc_next;
  logic            w_lt_signed;
  logic            w_lt_unsigned;

  alu_ctl_decode #(
    .MUL_EN (MUL_EN)
  ) u_decode (
    .i_alu_op  (alu_op),
    .i_funct7  (funct7),
    .i_funct3  (funct3),
    .o_alu_ctl (w_ctl)
  );

  assign w_shamt       = op_b[SHW-1:0];
  assign w_lt_signed   = ($signed(op_a) < $signed(op_b));
  assign w_lt_unsigned = (op_a < op_b);

  // Single-cycle datapath; MUL never takes this path, it goes to the loop.
  always_comb begin
    w_alu_res = op_a & op_b;
    case (w_ctl)
      ALU_AND:  w_alu_res = op_a & op_b;
      ALU_OR:   w_alu_res = op_a | op_b;
      ALU_ADD:  w_alu_res = op_a + op_b;
      ALU_XOR:  w_alu_res = op_a ^ op_b;
      ALU_SUB:  w_alu_res = op_a - op_b;
      ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_signed};
      ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      ALU_SLL:  w_alu_res = op_a << w_shamt;
      ALU_SRL:  w_alu_res = op_a >> w_shamt;
      ALU_SRA:  w_alu_res = $signed(op_a) >>> w_shamt;
      default:  w_alu_res = op_a & op_b;
    endcase
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  // The low XLEN bits are the same for signed and unsigned operands.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Control FSM, result register and multiplier loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_ctl    <= ALU_AND;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_mul(w_ctl)) begin
              // result/alu_ctl keep the previous op until MUL completes.
              r_mcand  <= op_a;
              r_mplier <= op_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= ST_MUL_BUSY;
            end else begin
              r_result <= w_alu_res;
              r_ctl    <= w_ctl;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_MUL_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == CNT_LAST) begin
            // Last iteration: publish the accumulator including this step.
            r_result <= w_acc_next;
            r_ctl    <= ALU_MUL;
            r_cnt    <= '0;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign alu_ctl   = r_ctl;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: transaction-level reference model compared every
// cycle, directed cases with literal expectations, then random traffic.
module tb_alu_seq_unit;

  localparam int XLEN = 32;
  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3;
  localparam logic [3:0] C_SUB = 4'h6, C_SLT = 4'h7, C_SLTU = 4'h8, C_SLL = 4'h9;
  localparam logic [3:0] C_SRL = 4'hA, C_SRA = 4'hB, C_MUL = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        in_ready, out_valid, zero;
  logic [31:0] result;
  logic [3:0]  alu_ctl;

  logic        z_in_valid = 1'b0, z_out_ready = 1'b0;
  logic        z_in_ready, z_out_valid, z_zero;
  logic [31:0] z_result;
  logic [3:0]  z_alu_ctl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ntx = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq_unit #(.XLEN(XLEN), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .alu_ctl(alu_ctl)
  );

  alu_seq_unit #(.XLEN(XLEN), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .result(z_result),
    .zero(z_zero), .alu_ctl(z_alu_ctl)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Decode table as written in the instruction-set description.
  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [6:0] f7,
                                         input logic [2:0] f3, input bit mul_en);
    logic [3:0] key;
    key = {f7[5], f3};
    if (op == 2'b00) return C_ADD;
    if (op == 2'b01) return C_SUB;
    if (op == 2'b10) begin
      if (f7 == 7'b0000001 && f3 == 3'b000) return mul_en ? C_MUL : C_ADD;
      case (key)
        4'b0000: return C_ADD;
        4'b1000: return C_SUB;
        4'b0111: return C_AND;
        4'b0110: return C_OR;
        4'b0100: return C_XOR;
        4'b0010: return C_SLT;
        4'b0011: return C_SLTU;
        4'b0001: return C_SLL;
        4'b0101: return C_SRL;
        4'b1101: return C_SRA;
        default: return C_AND;
      endcase
    end
    case (f3)
      3'b000: return C_ADD;
      3'b111: return C_AND;
      3'b110: return C_OR;
      3'b100: return C_XOR;
      3'b010: return C_SLT;
      3'b011: return C_SLTU;
      3'b001: return C_SLL;
      3'b101: return f7[5] ? C_SRA : C_SRL;
      default: return C_AND;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      C_OR:    r = a | b;
      C_ADD:   r = a + b;
      C_XOR:   r = a ^ b;
      C_SUB:   r = a - b;
      C_SLT:   r = {31'b0, ($signed(a) < $signed(b))};
      C_SLTU:  r = {31'b0, (a < b)};
      C_SLL:   r = a << b[4:0];
      C_SRL:   r = a >> b[4:0];
      C_SRA:   r = $signed(a) >>> b[4:0];
      C_MUL:   r = a * b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Reference model: idle / waiting (with cycles left) / holding a result.
  bit          m_idle, m_valid;
  int          m_wait;
  logic [31:0] m_res, m_pres;
  logic [3:0]  m_ctl, m_pctl;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1; m_valid = 0; m_wait = 0; m_res = '0; m_ctl = C_AND;
    end else if (m_valid) begin
      if (out_ready) begin
        ntx++;
        $display("txn %0d ctl=%h result=%h", ntx, m_ctl, m_res);
        m_valid = 0; m_idle = 1;
      end
    end else if (!m_idle) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1; m_res = m_pres; m_ctl = m_pctl;
      end
    end else if (in_valid) begin
      m_pctl = ref_ctl(alu_op, funct7, funct3, 1'b1);
      m_pres = ref_res(m_pctl, op_a, op_b);
      m_idle = 0;
      if (m_pctl == C_MUL) m_wait = XLEN;
      else begin
        m_valid = 1; m_res = m_pres; m_ctl = m_pctl;
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(m_idle));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("result", 64'(result), 64'(m_res));
    chk("zero", 64'(zero), 64'(m_res == 32'h0));
    chk("alu_ctl", 64'(alu_ctl), 64'(m_ctl));
  end

  // Issue one op, check the literal result and latency, optionally stall.
  task automatic do_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic [3:0] exp_c,
                       input int exp_lat, input int hold, input string nm);
    int n;
    logic [31:0] r;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1; alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    chk({nm, "_result"}, 64'(result), 64'(exp_r));
    chk({nm, "_ctl"}, 64'(alu_ctl), 64'(exp_c));
    chk({nm, "_zero"}, 64'(zero), 64'(exp_r == 32'h0));
    for (int k = 0; k < hold; k++) begin
      r = $urandom;
      in_valid = 1; alu_op = 2'b00; op_a = r; op_b = 32'h1;
      @(negedge clk);
    end
    if (hold > 0) begin
      chk({nm, "_stall_result"}, 64'(result), 64'(exp_r));
      chk({nm, "_stall_in_ready"}, 64'(in_ready), 64'(0));
      chk({nm, "_stall_out_valid"}, 64'(out_valid), 64'(1));
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, "_release_idle"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [31:0] r;
    int n;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1));
    chk("rst_ctl", 64'(alu_ctl), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));

    // MUL_EN=0 instance: MUL encoding behaves as a single-cycle ADD.
    z_in_valid = 1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
    op_a = 32'h0001_0003; op_b = 32'h0000_0005;
    @(negedge clk);
    z_in_valid = 0;
    chk("nomul_valid", 64'(z_out_valid), 64'(1));
    chk("nomul_result", 64'(z_result), 64'(32'h0001_0008));
    chk("nomul_ctl", 64'(z_alu_ctl), 64'(C_ADD));
    chk("nomul_zero", 64'(z_zero), 64'(0));
    z_out_ready = 1;
    @(negedge clk);
    z_out_ready = 0;
    chk("nomul_idle", 64'(z_in_ready), 64'(1));

    do_op(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, C_SUB, 0, 0, "sub");
    do_op(2'b11, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, C_SRA, 0, 0, "srai");
    do_op(2'b11, 7'b0000000, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, C_SRL, 0, 0, "srli");
    do_op(2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, C_SLT, 0, 0, "slt");
    do_op(2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, C_SLTU, 0, 0, "sltu");
    do_op(2'b01, 7'b0000000, 3'b000, 32'd9, 32'd9, 32'd0, C_SUB, 0, 0, "branch");
    do_op(2'b10, 7'b0000001, 3'b000, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, C_MUL, 32, 0, "mul");
    do_op(2'b10, 7'b0000000, 3'b001, 32'h0000_0003, 32'd36, 32'h0000_0030, C_SLL, 0, 0, "sll_mask");
    do_op(2'b10, 7'b0000000, 3'b111, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, C_AND, 0, 0, "and");
    do_op(2'b10, 7'b1000000, 3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, C_ADD, 0, 0, "rtype_add_f7b6");
    do_op(2'b00, 7'b0000000, 3'b000, 32'h10, 32'h20, 32'h30, C_ADD, 0, 10, "backpressure");

    // Reset in the middle of a multiply (cnt == 10).
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
    op_a = 32'h1234; op_b = 32'h77;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    chk("midmul_busy", 64'(in_ready), 64'(0));
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midmul_rst_idle", 64'(in_ready), 64'(1));
    chk("midmul_rst_valid", 64'(out_valid), 64'(0));
    chk("midmul_rst_result", 64'(result), 64'(0));
    chk("midmul_rst_zero", 64'(zero), 64'(1));
    chk("midmul_rst_ctl", 64'(alu_ctl), 64'(0));
    do_op(2'b00, 7'b0000000, 3'b000, 32'd2, 32'd3, 32'd5, C_ADD, 0, 0, "add_after_rst");

    // Random traffic; the per-cycle comparison does the checking.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom;
      in_valid  = (r[1:0] != 2'b00);
      out_ready = r[2];
      alu_op    = r[4:3];
      case (r[6:5])
        2'd0: funct7 = 7'b0000000;
        2'd1: funct7 = 7'b0100000;
        2'd2: funct7 = 7'b0000001;
        default: funct7 = r[13:7];
      endcase
      funct3 = r[16:14];
      if (alu_op == 2'b10 && funct7 == 7'b0000001 && r[17]) funct3 = 3'b000;
      rst = (r[31:22] == 10'h155);
      r = $urandom;
      op_a = r[18] ? {28'h0, r[3:0]} : $urandom;
      op_b = r[19] ? {28'h0, r[7:4]} : $urandom;
      @(negedge clk);
    end
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (40) @(negedge clk);
    out_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised execute unit that merges ALU-control decode with a registered datapath and an iterative multiplier. It sits between decode and writeback. It accepts {ALUOp, funct7, funct3, operands} under a valid/ready handshake. Single-cycle operations return a result one cycle after acceptance; MUL returns after XLEN iteration cycles. It extends the existing 4-bit ALUCtl encoding with XOR, SLTU, shifts and MUL.

## Interface
Parameters:
- XLEN, 32: operand/result width (≥8, power of two)
- MUL_EN, 1: 1 = MUL supported; 0 = MUL decodes as ADD

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept (state IDLE)
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- op_a, op_b  in  XLEN  operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0
- alu_ctl  out  4  decoded code of the op held in result

## Operation
- Decode (combinational, sampled at accept). ALUCtl codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - SUB 0110, SLT 0111, SLTU 1000
  - SLL 1001, SRL 1010, SRA 1011, MUL 1100
- alu_op 00 → ADD; alu_op 01 → SUB.
- alu_op 10 (R-type):
  - funct7=0000001, funct3=000 → MUL.
  - Otherwise use {funct7[5], funct3}: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0010 SLT, 0011 SLTU, 0001 SLL, 0101 SRL, 1101 SRA.
- alu_op 11 (I-type): funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU, 001 SLL; 101 gives SRA if funct7[5] else SRL.
- Any unlisted combination → AND (0000).
- Arithmetic:
  - All results mod 2^XLEN.
  - SLT is signed, SLTU unsigned; both give result 1 or 0.
  - Shift amount is op_b[$clog2(XLEN)-1:0].
  - MUL returns the low XLEN bits of the product (sign-agnostic).
- FSM, three states:
  - IDLE: in_ready=1. Accepting a non-MUL op → result latched → DONE. Accepting MUL → load multiplicand/multiplier, clear accumulator, cnt=0 → MUL_BUSY.
  - MUL_BUSY: each cycle, if multiplier LSB=1, add multiplicand to accumulator; shift multiplicand left and multiplier right; cnt++. At cnt==XLEN-1 → DONE with the final accumulator.
  - DONE: out_valid=1; result, zero and alu_ctl held stable. out_ready=1 → IDLE.
- in_ready=0 outside IDLE. in_valid there is ignored (not queued).
- alu_ctl and zero reflect the op currently held in result.

## Timing
- Reset (any state, including mid-MUL): state=IDLE, out_valid=0, result=0, zero=1, alu_ctl=0000, cnt=0. The in-flight op is discarded.
- Single-cycle op accepted at edge N → out_valid high after edge N+1.
- MUL accepted at edge N → out_valid high after edge N+XLEN+1.
- out_valid held until an out_ready handshake. Result stable while stalled.
- The DONE→IDLE edge and the next accept cannot coincide. Peak throughput is one op per 2 cycles (single-cycle ops).
- in_valid and out_ready are sampled only on rising clk. No combinational in→out path except in_ready, which derives from state.

## Structure
- Package alu_pkg:
  - ALUCtl localparams (4-bit codes above)
  - alu_op codes
  - FSM state typedef (IDLE, MUL_BUSY, DONE)
- Sub-module alu_ctl_decode (combinational decode → 4-bit alu_ctl). Reusable by the single-cycle core.
- Iterative multiplier stays inline in alu_seq_unit.

## Test plan
- R-type SUB: funct7=0100000, funct3=000, a=5, b=7 → 1 cycle later out_valid, result=0xFFFFFFFE, alu_ctl=0110, zero=0.
- I-type SRA vs SRL: a=0x80000000, b=4. With funct7[5]=1 → 0xF8000000. With funct7[5]=0 → 0x08000000.
- SLT vs SLTU: a=0xFFFFFFFF, b=1. SLT → 1, SLTU → 0. Branch op (alu_op=01) with a=b=9 → result=0, zero=1.
- MUL: a=0x0001_0003, b=0x0000_0005, accepted at edge N. in_ready=0 through N+32. out_valid asserted after edge N+33, result=0x0005_000F. Repeat with MUL_EN=0 → ADD, 1-cycle latency, result=0x0001_0008.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, new in_valid ignored. Release → IDLE next cycle.
- Reset mid-MUL at cnt=10 → next cycle IDLE, out_valid=0, result=0, zero=1. A following ADD 2+3 returns 5.
